// File: rtl/median_pkg.sv
// Shared types and schedule arithmetic for the median sort sequencer.
package median_pkg;

  typedef enum logic [1:0] {LOAD, SORT, OUT} state_t;

  function automatic int pass_count(input int n);
    return (n + 1) / 2;
  endfunction

  // Every pass is n slots long except the last, which is cut one slot short.
  function automatic int sort_cycles(input int n);
    return pass_count(n) * n - 1;
  endfunction

endpackage

// File: rtl/median_sched.sv
// Pass/cycle counter pair that walks the sort schedule: drives BYP and flags the
// final slot of the SORT phase.
module median_sched
  import median_pkg::*;
#(
  parameter int DATA_QTDE = 9
) (
  input  logic CLK,
  input  logic nRST,
  input  logic run,
  output logic byp,
  output logic sort_done
);

  localparam int PASSES      = pass_count(DATA_QTDE);
  localparam int SORT_CYCLES = sort_cycles(DATA_QTDE);
  localparam int CW          = $clog2(DATA_QTDE + 1);

  localparam logic [CW-1:0] LAST_PASS = CW'(PASSES - 1);
  localparam logic [CW-1:0] LAST_CYC  = CW'(DATA_QTDE - 1);
  localparam logic [CW-1:0] FINAL_CYC = CW'(SORT_CYCLES - (PASSES - 1) * DATA_QTDE - 1);

  logic [CW-1:0] pass_reg;
  logic [CW-1:0] cyc_reg;
  logic [CW-1:0] cmp_len;

  // Pass p compares during its first (DATA_QTDE-1-p) slots and bypasses the rest.
  assign cmp_len   = LAST_CYC - pass_reg;
  assign byp       = !run || (cyc_reg >= cmp_len);
  assign sort_done = run && (pass_reg == LAST_PASS) && (cyc_reg == FINAL_CYC);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      pass_reg <= '0;
      cyc_reg  <= '0;
    end else if (!run || sort_done) begin
      pass_reg <= '0;
      cyc_reg  <= '0;
    end else if (cyc_reg == LAST_CYC) begin
      cyc_reg  <= '0;
      pass_reg <= pass_reg + 1'b1;
    end else begin
      cyc_reg <= cyc_reg + 1'b1;
    end
  end

endmodule

// File: rtl/median_seq.sv
// Sequencer feeding one pixel window into the external sort stage and returning
// its median. Optional hand-off counter WIN_CNT under MEDIAN_SEQ_STATS_EN.
module median_seq
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_QTDE  = 9
) (
  input  logic                  CLK,
  input  logic                  nRST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic [DATA_WIDTH-1:0] MED_DI,
  output logic                  MED_DSI,
  output logic                  MED_BYP,
  input  logic [DATA_WIDTH-1:0] MED_DO,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [DATA_WIDTH-1:0] OUT_DATA
`ifdef MEDIAN_SEQ_STATS_EN
  ,
  output logic [15:0]           WIN_CNT
`endif
);

  localparam int CW = $clog2(DATA_QTDE + 1);
  localparam logic [CW-1:0] LAST_LOAD = CW'(DATA_QTDE - 1);

  state_t        state_reg;
  logic [CW-1:0] load_cnt_reg;
  logic          sched_run;
  logic          sched_byp;
  logic          sort_done;

  // Hold the schedule off while the last pixel's DSI pulse is still landing.
  assign sched_run = (state_reg == SORT) && !MED_DSI;

  median_sched #(
    .DATA_QTDE(DATA_QTDE)
  ) u_sched (
    .CLK      (CLK),
    .nRST     (nRST),
    .run      (sched_run),
    .byp      (sched_byp),
    .sort_done(sort_done)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg    <= LOAD;
      load_cnt_reg <= '0;
      IN_READY     <= 1'b0;
      MED_DI       <= '0;
      MED_DSI      <= 1'b0;
      MED_BYP      <= 1'b1;
      OUT_VALID    <= 1'b0;
      OUT_DATA     <= '0;
    end else begin
      MED_DSI <= 1'b0;
      case (state_reg)
        LOAD: begin
          IN_READY <= 1'b1;
          MED_BYP  <= 1'b1;
          if (IN_VALID && IN_READY) begin
            MED_DI  <= IN_DATA;
            MED_DSI <= 1'b1;
            if (load_cnt_reg == LAST_LOAD) begin
              load_cnt_reg <= '0;
              IN_READY     <= 1'b0;
              state_reg    <= SORT;
            end else begin
              load_cnt_reg <= load_cnt_reg + 1'b1;
            end
          end
        end
        SORT: begin
          MED_BYP <= sched_byp;
          if (sort_done) begin
            OUT_VALID <= 1'b1;
            OUT_DATA  <= MED_DO;
            state_reg <= OUT;
          end
        end
        OUT: begin
          MED_BYP <= 1'b1;
          if (OUT_READY) begin
            OUT_VALID <= 1'b0;
            IN_READY  <= 1'b1;
            state_reg <= LOAD;
          end
        end
        default: state_reg <= LOAD;
      endcase
    end
  end

`ifdef MEDIAN_SEQ_STATS_EN
  logic [15:0] win_cnt_reg;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      win_cnt_reg <= '0;
    end else if (OUT_VALID && OUT_READY && (win_cnt_reg != 16'hFFFF)) begin
      win_cnt_reg <= win_cnt_reg + 1'b1;
    end
  end

  assign WIN_CNT = win_cnt_reg;
`endif

endmodule

// File: tb/tb_median_seq.sv
// Directed and random windows through median_seq plus a behavioural bubble-sort stage.
module tb_median_seq;
  import median_pkg::*;

  localparam int DW  = 8;
  localparam int NQ  = 9;
  localparam int MID = (NQ - 1) / 2;
  localparam int LAT = sort_cycles(NQ) + 1;

  logic          CLK = 1'b0;
  logic          nRST;
  logic          IN_VALID;
  logic          IN_READY;
  logic [DW-1:0] IN_DATA;
  logic [DW-1:0] MED_DI;
  logic          MED_DSI;
  logic          MED_BYP;
  logic [DW-1:0] MED_DO;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] OUT_DATA;
`ifdef MEDIAN_SEQ_STATS_EN
  logic [15:0]   WIN_CNT;
`endif

  median_seq #(.DATA_WIDTH(DW), .DATA_QTDE(NQ)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_DATA  (IN_DATA),
    .MED_DI   (MED_DI),
    .MED_DSI  (MED_DSI),
    .MED_BYP  (MED_BYP),
    .MED_DO   (MED_DO),
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .OUT_DATA (OUT_DATA)
`ifdef MEDIAN_SEQ_STATS_EN
    ,
    .WIN_CNT  (WIN_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Sort stage: DSI shifts a pixel in, BYP=0 does one bubble compare at index j,
  // BYP=1 with DSI=0 freezes the data and rewinds j for the next pass.
  logic [DW-1:0] st [NQ] = '{default: '0};
  int st_j = 0;
  always @(posedge CLK) begin
    if (MED_DSI) begin
      for (int i = NQ - 1; i > 0; i--) st[i] <= st[i-1];
      st[0] <= MED_DI;
      st_j  <= 0;
    end else if (!MED_BYP) begin
      if (st_j < NQ - 1 && st[st_j] > st[st_j+1]) begin
        st[st_j]   <= st[st_j+1];
        st[st_j+1] <= st[st_j];
      end
      st_j <= st_j + 1;
    end else begin
      st_j <= 0;
    end
  end
  assign MED_DO = st[MID];

  int checks = 0;
  int errors = 0;
  int t_acc  = 0;
  logic [DW-1:0] win [NQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Rank-based median: the element with at most MID smaller and more than MID not larger.
  function automatic logic [DW-1:0] model_median(input logic [DW-1:0] w [NQ]);
    for (int i = 0; i < NQ; i++) begin
      int lt = 0;
      int le = 0;
      for (int j = 0; j < NQ; j++) begin
        if (w[j] < w[i]) lt++;
        if (w[j] <= w[i]) le++;
      end
      if (lt <= MID && le > MID) return w[i];
    end
    return '0;
  endfunction

  task automatic send(input logic [DW-1:0] v);
    int n = 0;
    @(negedge CLK);
    IN_VALID = 1'b1;
    IN_DATA  = v;
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (n >= 200) chk("in_ready_timeout", IN_READY, 1);
    @(posedge CLK);
    #1;
    t_acc    = cyc;
    IN_VALID = 1'b0;
    chk("med_dsi", MED_DSI, 1);
    chk("med_di", MED_DI, v);
    chk("med_byp_load", MED_BYP, 1);
  endtask

  task automatic send_win(input int gaps);
    for (int i = 0; i < NQ; i++) begin
      if (gaps != 0) @(negedge CLK);
      send(win[i]);
    end
  endtask

  task automatic recv(input logic [DW-1:0] exp, input int hold);
    int   n  = 0;
    logic ok = 1'b1;
    @(negedge CLK);
    while (!OUT_VALID && n < 400) begin
      @(negedge CLK);
      n++;
    end
    chk("latency", cyc - t_acc, LAT);
    chk("out_data", OUT_DATA, exp);
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      ok = ok && (OUT_VALID === 1'b1) && (OUT_DATA === exp) && (IN_READY === 1'b0);
    end
    if (hold > 0) chk("hold_stable", ok, 1);
    OUT_READY = 1'b1;
    @(posedge CLK);
    #1;
    OUT_READY = 1'b0;
    chk("out_valid_drop", OUT_VALID, 0);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    nRST = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  initial begin
    nRST      = 1'b0;
    IN_VALID  = 1'b0;
    IN_DATA   = '0;
    OUT_READY = 1'b0;
    repeat (3) @(negedge CLK);
    chk("rst_in_ready", IN_READY, 0);
    chk("rst_dsi", MED_DSI, 0);
    chk("rst_byp", MED_BYP, 1);
    chk("rst_di", MED_DI, 0);
    chk("rst_out_valid", OUT_VALID, 0);
    chk("rst_out_data", OUT_DATA, 0);
`ifdef MEDIAN_SEQ_STATS_EN
    chk("rst_win_cnt", WIN_CNT, 0);
`endif
    nRST = 1'b1;
    #1;
    chk("in_ready_first_cycle", IN_READY, 0);
    @(negedge CLK);
    chk("in_ready_after", IN_READY, 1);

    // 1: ascending 1..9
    for (int i = 0; i < NQ; i++) win[i] = DW'(i + 1);
    send_win(0);
    recv(8'd5, 0);

    // OUT_READY while idle in LOAD is ignored
    OUT_READY = 1'b1;
    repeat (3) @(negedge CLK);
    chk("idle_ready_ignored", OUT_VALID, 0);
    chk("idle_in_ready", IN_READY, 1);
    OUT_READY = 1'b0;

    // 2: descending, then alternating extremes back-to-back
    for (int i = 0; i < NQ; i++) win[i] = DW'(NQ - i);
    send_win(0);
    recv(8'd5, 0);
    for (int i = 0; i < NQ - 1; i++) win[i] = (i % 2 == 0) ? 8'd255 : 8'd0;
    win[NQ-1] = 8'd128;
    send_win(0);
    recv(8'd128, 0);

    // 3: IN_VALID gaps between pixels
    win = '{8'd9, 8'd3, 8'd7, 8'd1, 8'd5, 8'd2, 8'd8, 8'd6, 8'd4};
    send_win(1);
    recv(8'd5, 0);

    // 4: downstream stalls 20 cycles
    win = '{8'd50, 8'd40, 8'd30, 8'd20, 8'd10, 8'd60, 8'd70, 8'd80, 8'd90};
    send_win(0);
    recv(8'd50, 20);

    // 5: reset mid-window discards the partial load
    for (int i = 0; i < 4; i++) send(8'd200);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    chk("abort_in_ready", IN_READY, 0);
    chk("abort_byp", MED_BYP, 1);
    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < NQ; i++) win[i] = 8'd10;
    send_win(0);
    recv(8'd10, 0);

    // 6: random windows against the rank model
    pulse_reset();
    for (int w = 0; w < 1000; w++) begin
      for (int i = 0; i < NQ; i++) win[i] = DW'($urandom_range(0, 255));
      send_win(($urandom_range(0, 3) == 0) ? 1 : 0);
      recv(model_median(win), $urandom_range(0, 2));
    end
`ifdef MEDIAN_SEQ_STATS_EN
    chk("win_cnt", WIN_CNT, 1000);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
